// File: rtl/i2c_sched_pkg.sv
// Shared definitions for the I2C SCL bit-timing scheduler.
//
// Contents:
//   sched_state_e  - 3-bit phase encoding (IDLE, LOW1, LOW2, HIGH1, HIGH2)
//   DIV_MIN        - smallest quarter-period divisor the scheduler will run with
//   *_DEF          - default parameter values for the scheduler and its timer
//   is_low_phase   - true for the two phases in which the master pulls SCL low
package i2c_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW1  = 3'd1,
    ST_LOW2  = 3'd2,
    ST_HIGH1 = 3'd3,
    ST_HIGH2 = 3'd4
  } sched_state_e;

  localparam int DIV_MIN     = 2;
  localparam int DIV_W_DEF   = 16;
  localparam int DIV_RST_DEF = 125;
  localparam int TMO_W_DEF   = 20;

  // SCL is driven low during both halves of the low period only.
  function automatic logic is_low_phase(input sched_state_e s);
    return (s == ST_LOW1) || (s == ST_LOW2);
  endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// Quarter-bit down-counter used to time each SCL phase.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - load load_val this edge (phase entry); wins over en
//   load_val    - value loaded on phase entry (divisor minus one)
//   en          - count enable; low holds the current value (clock stretch)
//   phase_end   - high while the counter reads zero (last cycle of a phase)
module i2c_qtr_timer
  import i2c_sched_pkg::*;
#(
  parameter int CNT_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             phase_end
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load on phase entry, otherwise count down and park at zero; the
  // scheduler only looks at phase_end while a timed phase is active.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end = (cnt_q == '0);

endmodule

// File: rtl/i2c_scl_sched.sv
// I2C master SCL bit-timing scheduler.
//
// Each granted bit slot walks LOW1 -> LOW2 -> HIGH1 -> HIGH2, each phase one
// quarter period (div_q clk cycles). HIGH1 only counts once the synchronised
// SCL pin is seen high, so a stretching slave lengthens it.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   div_val      - new quarter-period divisor (clamped to DIV_MIN)
//   div_load     - load div_val; accepted only while IDLE
//   bit_req      - host bit-slot request, level held until bit_ack
//   bit_ack      - one-cycle grant pulse; the bit starts next cycle
//   abort        - synchronous abort: release SCL and return to IDLE
//   scl_in       - raw (asynchronous) SCL pin level
//   tmo_val      - stretch timeout in HIGH1 cycles (optional feature only)
//   scl_oe       - 1 = pull SCL low, 0 = release
//   data_tick    - pulse at mid-low, SDA may change
//   sample_tick  - pulse at mid-high, SDA is sampled
//   bit_done     - pulse on the last cycle of the bit
//   busy         - registered "not IDLE"
//   stretch_err  - sticky stretch-timeout flag
//
// Optional feature macro: I2C_SCL_STRETCH_TIMEOUT_EN adds the tmo_val port
// and the stretch timeout. Without it stretching waits forever and
// stretch_err is tied low.
module i2c_scl_sched
  import i2c_sched_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  input  logic             bit_req,
  output logic             bit_ack,
  input  logic             abort,
  input  logic             scl_in,
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  input  logic [TMO_W-1:0] tmo_val,
`endif
  output logic             scl_oe,
  output logic             data_tick,
  output logic             sample_tick,
  output logic             bit_done,
  output logic             busy,
  output logic             stretch_err
);

  sched_state_e     state_q;
  sched_state_e     state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             sync1_q;
  logic             sync1_d;
  logic             scl_s_q;
  logic             scl_s_d;
  logic             scl_oe_q;
  logic             scl_oe_d;
  logic             busy_q;
  logic             busy_d;

  logic             tmr_load;
  logic             tmr_en;
  logic             phase_end;
  logic             tmo_hit;

  i2c_qtr_timer #(
    .CNT_W(DIV_W)
  ) u_qtr_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (div_q - DIV_W'(1)),
    .en       (tmr_en),
    .phase_end(phase_end)
  );

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_d;
  logic [TMO_W-1:0] tmo_inc;
  logic             stretch_err_q;
  logic             stretch_err_d;

  // Count HIGH1 cycles in which the slave still holds SCL low. The count
  // restarts on every HIGH1 entry; the error flag survives until the next
  // grant so the host can see why the previous bit vanished.
  always_comb begin
    tmo_inc       = tmo_cnt_q + TMO_W'(1);
    tmo_hit       = (state_q == ST_HIGH1) && !scl_s_q && (tmo_inc >= tmo_val);
    tmo_cnt_d     = tmo_cnt_q;
    stretch_err_d = stretch_err_q;
    if ((state_d == ST_HIGH1) && (state_q != ST_HIGH1)) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_HIGH1) && !scl_s_q) begin
      tmo_cnt_d = tmo_inc;
    end
    if (bit_ack) begin
      stretch_err_d = 1'b0;
    end else if (tmo_hit) begin
      stretch_err_d = 1'b1;
    end
  end

  assign stretch_err = stretch_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign stretch_err = 1'b0;
`endif

  // Next-state and strobe decode. Strobes come from the registered state and
  // the registered timer, so they are single clean pulses; bit_ack must
  // answer bit_req in the same cycle and is therefore decoded here too.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sync1_d     = scl_in;
    scl_s_d     = sync1_q;
    bit_ack     = 1'b0;
    data_tick   = 1'b0;
    sample_tick = 1'b0;
    bit_done    = 1'b0;
    tmr_en      = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (div_load) begin
          div_d = (div_val < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_val;
        end
        if (bit_req) begin
          bit_ack = 1'b1;
          state_d = ST_LOW1;
        end
      end
      ST_LOW1: begin
        if (phase_end) begin
          data_tick = 1'b1;
          state_d   = ST_LOW2;
        end
      end
      ST_LOW2: begin
        if (phase_end) begin
          state_d = ST_HIGH1;
        end
      end
      ST_HIGH1: begin
        tmr_en = scl_s_q;
        if (tmo_hit) begin
          state_d = ST_IDLE;
        end else if (phase_end) begin
          sample_tick = 1'b1;
          state_d     = ST_HIGH2;
        end
      end
      ST_HIGH2: begin
        if (phase_end) begin
          bit_done = 1'b1;
          if (bit_req) begin
            bit_ack = 1'b1;
            state_d = ST_LOW1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats everything: no strobes this cycle, straight back to IDLE.
    if (abort) begin
      state_d     = ST_IDLE;
      bit_ack     = 1'b0;
      data_tick   = 1'b0;
      sample_tick = 1'b0;
      bit_done    = 1'b0;
    end

    tmr_load = (state_d != state_q) && (state_d != ST_IDLE);
    scl_oe_d = is_low_phase(state_d);
    busy_d   = (state_d != ST_IDLE);
  end

  // All scheduler state. The synchroniser resets to 1 to match an idle,
  // pulled-up bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      div_q         <= DIV_W'(DIV_RST);
      sync1_q       <= 1'b1;
      scl_s_q       <= 1'b1;
      scl_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      stretch_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      sync1_q       <= sync1_d;
      scl_s_q       <= scl_s_d;
      scl_oe_q      <= scl_oe_d;
      busy_q        <= busy_d;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      stretch_err_q <= stretch_err_d;
`endif
    end
  end

  assign scl_oe = scl_oe_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_scl_sched.sv
// Self-checking bench for i2c_scl_sched.
// A simple slave model drives scl_in from scl_oe, holding the line low for a
// chosen number of cycles after each release. Expected event timing comes
// from the bit-period arithmetic (phase = d cycles, HIGH1 = d + 2 + stretch).
module tb_i2c_scl_sched;

  localparam int DIV_W = 16;
  localparam int TMO_W = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             bit_req;
  logic             abort;
  logic             scl_in;
  logic             bit_ack;
  logic             scl_oe;
  logic             data_tick;
  logic             sample_tick;
  logic             bit_done;
  logic             busy;
  logic             stretch_err;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_val;
`endif

  int checks = 0;
  int errors = 0;
  int stretch_cycles = 0;
  bit stuck_low = 1'b0;
  int rel_cnt = 1000;

  typedef struct {
    bit              do_load;
    logic [DIV_W-1:0] dv;
    int              stretch;
    int              e_data;
    int              e_sample;
    int              e_done;
    int              e_oe;
  } vec_t;

  vec_t vecs[7];

  i2c_scl_sched #(
    .DIV_W  (DIV_W),
    .DIV_RST(125),
    .TMO_W  (TMO_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_val    (div_val),
    .div_load   (div_load),
    .bit_req    (bit_req),
    .bit_ack    (bit_ack),
    .abort      (abort),
    .scl_in     (scl_in),
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    .tmo_val    (tmo_val),
`endif
    .scl_oe     (scl_oe),
    .data_tick  (data_tick),
    .sample_tick(sample_tick),
    .bit_done   (bit_done),
    .busy       (busy),
    .stretch_err(stretch_err)
  );

  always #5 clk = ~clk;

  // Wired-AND bus with a slave that keeps SCL low for stretch_cycles cycles
  // after the master lets go (or forever while stuck_low is set).
  initial scl_in = 1'b1;
  always @(negedge clk) begin
    if (scl_oe) begin
      rel_cnt = 0;
      scl_in  = 1'b0;
    end else begin
      scl_in  = !stuck_low && (rel_cnt >= stretch_cycles);
      rel_cnt = rel_cnt + 1;
    end
  end

  // Hard stop in case something upstream goes badly wrong.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then return at the
  // sampling point for that cycle.
  task automatic applyStimulus(input logic req, input logic ab, input logic ld,
                               input logic [DIV_W-1:0] dv);
    @(posedge clk);
    #1;
    bit_req  = req;
    abort    = ab;
    div_load = ld;
    div_val  = dv;
    #1;
  endtask

  // Request one bit from IDLE and record when each strobe appears, relative
  // to the grant cycle. Offsets stay -1 if the event never happens.
  task automatic runBit(input int stretch, output logic ack0, output int t_data,
                        output int t_sample, output int t_done, output int n_data,
                        output int n_sample, output int n_oe, output logic idle_after);
    bit got_done;
    stretch_cycles = stretch;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    ack0 = bit_ack;
    t_data = -1; t_sample = -1; t_done = -1;
    n_data = 0; n_sample = 0; n_oe = 0;
    got_done = 1'b0;
    for (int r = 1; r <= 700 && !got_done; r++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      if (scl_oe) n_oe++;
      if (data_tick) begin
        n_data++;
        if (t_data < 0) t_data = r;
      end
      if (sample_tick) begin
        n_sample++;
        if (t_sample < 0) t_sample = r;
      end
      if (bit_done) begin
        t_done = r;
        got_done = 1'b1;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    idle_after = !busy && !scl_oe;
  endtask

  // Main sequence: reset, table of single bits, multi-cycle corner cases,
  // then randomised traffic against the timing model.
  initial begin
    logic ack0, idle_after;
    int t_data, t_sample, t_done, n_data, n_sample, n_oe;
    int pat_err, n_ack, n_done, n_s;
    int d;

    rst_n    = 1'b0;
    div_val  = '0;
    div_load = 1'b0;
    bit_req  = 1'b0;
    abort    = 1'b0;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    tmo_val  = TMO_W'(1000);
`endif

    vecs[0] = '{1'b0, 16'd0, 0, 125, 377, 502, 250};
    vecs[1] = '{1'b1, 16'd5, 0, 5, 17, 22, 10};
    vecs[2] = '{1'b1, 16'd5, 7, 5, 24, 29, 10};
    vecs[3] = '{1'b1, 16'd0, 0, 2, 8, 10, 4};
    vecs[4] = '{1'b1, 16'd1, 2, 2, 10, 12, 4};
    vecs[5] = '{1'b1, 16'd9, 3, 9, 32, 41, 18};
    vecs[6] = '{1'b1, 16'd3, 0, 3, 11, 14, 6};

    #22;
    checkOutput("reset_outputs",
                {scl_oe, bit_ack, data_tick, sample_tick, bit_done, busy, stretch_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Single bits: reset divisor first, then loaded and clamped divisors
    // with and without slave stretching.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_load) begin
        applyStimulus(1'b0, 1'b0, 1'b1, vecs[i].dv);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
      end
      runBit(vecs[i].stretch, ack0, t_data, t_sample, t_done, n_data, n_sample, n_oe, idle_after);
      checkOutput($sformatf("v%0d_ack", i), ack0, 1);
      checkOutput($sformatf("v%0d_data_at", i), t_data, vecs[i].e_data);
      checkOutput($sformatf("v%0d_sample_at", i), t_sample, vecs[i].e_sample);
      checkOutput($sformatf("v%0d_done_at", i), t_done, vecs[i].e_done);
      checkOutput($sformatf("v%0d_n_data", i), n_data, 1);
      checkOutput($sformatf("v%0d_n_sample", i), n_sample, 1);
      checkOutput($sformatf("v%0d_oe_cycles", i), n_oe, vecs[i].e_oe);
      checkOutput($sformatf("v%0d_idle_after", i), idle_after, 1);
    end
    stretch_cycles = 0;

    // Three back-to-back bits at d=5: 22-cycle period, grants on done.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    pat_err = 0; n_ack = 0; n_done = 0;
    for (int r = 0; r <= 70; r++) begin
      applyStimulus(n_ack < 3, 1'b0, 1'b0, '0);
      if (bit_ack !== ((r == 0) || (r == 22) || (r == 44))) pat_err++;
      if (bit_done !== ((r == 22) || (r == 44) || (r == 66))) pat_err++;
      if (busy !== ((r >= 1) && (r <= 66))) pat_err++;
      if (scl_oe !== ((r >= 1) && (r <= 66) && (((r - 1) % 22) < 10))) pat_err++;
      if (bit_ack) n_ack++;
      if (bit_done) n_done++;
    end
    checkOutput("b2b_pattern_errs", pat_err, 0);
    checkOutput("b2b_acks", n_ack, 3);
    checkOutput("b2b_dones", n_done, 3);

    // div_load while busy must not change the running divisor (d=2).
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("busyload_ack", bit_ack, 1);
    t_done = -1;
    for (int r = 1; r <= 40 && t_done < 0; r++) begin
      applyStimulus(1'b0, 1'b0, r == 3, (r == 3) ? 16'd9 : 16'd0);
      if (bit_done) t_done = r;
    end
    checkOutput("busyload_done_at", t_done, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    runBit(0, ack0, t_data, t_sample, t_done, n_data, n_sample, n_oe, idle_after);
    checkOutput("busyload_next_done_at", t_done, 10);

    // Abort in LOW2 with bit_req still high, then re-grant from IDLE.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("abort_first_ack", bit_ack, 1);
    n_data = 0; n_s = 0;
    for (int r = 1; r <= 6; r++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      if (data_tick) n_data++;
      if (sample_tick || bit_done || bit_ack) n_s++;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("abort_cycle_pulses", {bit_ack, data_tick, sample_tick, bit_done}, 0);
    checkOutput("abort_before_data", n_data, 1);
    checkOutput("abort_before_other", n_s, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("abort_release", {scl_oe, busy}, 0);
    checkOutput("abort_reack", bit_ack, 1);
    t_done = -1;
    for (int r = 1; r <= 40 && t_done < 0; r++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      if (bit_done) t_done = r;
    end
    checkOutput("abort_rebit_done_at", t_done, 22);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    // Slave never releases: timeout after 20 low HIGH1 cycles at d=5.
    tmo_val   = TMO_W'(20);
    stuck_low = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    t_done = -1; n_s = 0;
    for (int r = 1; r <= 80 && t_done < 0; r++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      if (sample_tick || bit_done) n_s++;
      if (stretch_err) begin
        t_done = r;
        checkOutput("tmo_idle_at_err", busy, 0);
      end
    end
    checkOutput("tmo_err_at", t_done, 31);
    checkOutput("tmo_no_sample", n_s, 0);
    stuck_low = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("tmo_err_sticky", stretch_err, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("tmo_reack", {bit_ack, stretch_err}, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("tmo_err_cleared", stretch_err, 0);
    for (int r = 2; r <= 40 && !bit_done; r++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tmo_val = TMO_W'(1000);
`endif

    // Reset in the middle of LOW1 releases SCL at once and restores DIV_RST.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    #1 rst_n = 1'b0;
    #1 checkOutput("midreset_outputs",
                   {scl_oe, data_tick, sample_tick, bit_done, busy, stretch_err}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    runBit(0, ack0, t_data, t_sample, t_done, n_data, n_sample, n_oe, idle_after);
    checkOutput("midreset_div_restored", t_data, 125);

    // Randomised traffic: per episode a random divisor, per bit a random
    // stretch, and either a held request or a random idle gap between bits.
    for (int ep = 0; ep < 8; ep++) begin
      int  bits_left, t_ack, s_cur, next_req, r, t;
      bit  active, req, e_ack, e_oe, e_busy, e_data, e_samp, e_done;
      logic [DIV_W-1:0] dv;
      dv = DIV_W'($urandom_range(0, 7));
      d  = (dv < 2) ? 2 : int'(dv);
      applyStimulus(1'b0, 1'b0, 1'b1, dv);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      bits_left = $urandom_range(3, 6);
      active = 1'b0; t_ack = 0; s_cur = 0; next_req = 0;
      for (t = 0; t < 3000 && (bits_left > 0 || active); t++) begin
        req = (bits_left > 0) && (t >= next_req);
        applyStimulus(req, 1'b0, 1'b0, '0);
        r      = t - t_ack;
        e_oe   = active && (r >= 1) && (r <= 2 * d);
        e_busy = active && (r >= 1);
        e_data = active && (r == d);
        e_samp = active && (r == 3 * d + 2 + s_cur);
        e_done = active && (r == 4 * d + 2 + s_cur);
        e_ack  = req && (!active || e_done);
        checkOutput($sformatf("rand_ep%0d_t%0d", ep, t),
                    {bit_ack, scl_oe, busy, data_tick, sample_tick, bit_done, stretch_err},
                    {e_ack, e_oe, e_busy, e_data, e_samp, e_done, 1'b0});
        if (e_done) active = 1'b0;
        if (e_ack) begin
          active = 1'b1;
          t_ack  = t;
          s_cur  = $urandom_range(0, 5);
          stretch_cycles = s_cur;
          bits_left--;
          if ($urandom_range(0, 1) == 1) next_req = t;
          else next_req = t + 4 * d + 2 + s_cur + 1 + $urandom_range(0, 4);
        end
      end
      checkOutput($sformatf("rand_ep%0d_complete", ep), (bits_left == 0) && !active, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
